// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: default
// geometry, pointer sizing and the sticky error-flag bundle.
package fifo_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 8;

   // Sticky error flags raised by rejected requests.
   typedef struct packed {
      logic overflow;
      logic underflow;
   } err_flags_t;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one
// registered read port. A read and a write to the same address in the
// same cycle return the old contents (read-first).
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Write port and registered read port share one process for block-RAM inference.
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO. Control, pointers, occupancy count,
// status flags and sticky errors live here; storage is in fifo_mem.
// Flags are decoded from the registered count so they line up with it.
module param_sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wrt_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd_en,
   input  logic             flush,
   input  logic             clr_err,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
   localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_out_valid;
   logic             r_dout_live;
   err_flags_t       r_err;

   logic             w_full;
   logic             w_empty;
   logic             w_rd_ok;
   logic             w_wr_ok;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_ovf_evt;
   logic             w_udf_evt;
   logic [WIDTH-1:0] w_rdata;
   logic             w_unused_wrap;

   // Status decode from the registered occupancy.
   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);

   // A write into a full FIFO is still taken when a read frees a slot
   // in the same cycle. There is no write-to-read bypass on empty.
   assign w_rd_ok = rd_en & ~w_empty;
   assign w_wr_ok = wrt_en & (~w_full | w_rd_ok);

   // Requests that actually touch state: flush and reset suppress them.
   assign w_rd_acc = w_rd_ok & ~flush & rstn;
   assign w_wr_acc = w_wr_ok & ~flush & rstn;

   // Rejected requests raise errors, but not while flushing.
   assign w_ovf_evt = wrt_en & ~w_wr_ok & ~flush;
   assign w_udf_evt = rd_en  & ~w_rd_ok & ~flush;

   // Wrap bits are kept for debug visibility; flags come from count.
   assign w_unused_wrap = r_wr_ptr[PW-1] ^ r_rd_ptr[PW-1];

   // Pointer and occupancy tracking; flush restarts from an empty state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
      end
   end

   // One-cycle valid strobe per accepted read; r_dout_live masks the
   // undefined RAM output register until the first read after reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_out_valid <= 1'b0;
         r_dout_live <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_rd_ok;
         if (w_rd_ok) begin
            r_dout_live <= 1'b1;
         end
      end
   end

   // Sticky error flags: a new error in the clear cycle wins.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_err <= '0;
      end else begin
         r_err.overflow  <= w_ovf_evt | (r_err.overflow  & ~clr_err);
         r_err.underflow <= w_udf_evt | (r_err.underflow & ~clr_err);
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (w_wr_acc),
      .waddr (r_wr_ptr[AW-1:0]),
      .wdata (data_in),
      .re    (w_rd_acc),
      .raddr (r_rd_ptr[AW-1:0]),
      .rdata (w_rdata)
   );

   assign data_out     = r_dout_live ? w_rdata : '0;
   assign out_valid    = r_out_valid;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= C_AF);
   assign almost_empty = (r_count <= C_AE);
   assign count        = r_count;
   assign overflow     = r_err.overflow;
   assign underflow    = r_err.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (WIDTH=32, DEPTH=4, AF=3, AE=1).
// Stimulus pushes the expected read word for every accepted read into a
// queue; an independent monitor pops and compares whenever out_valid.
module tb_param_sync_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rstn;
   logic             wrt_en;
   logic [WIDTH-1:0] data_in;
   logic             rd_en;
   logic             flush;
   logic             clr_err;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [31:0]      exp_q[$];

   param_sync_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .AF_THRESH (3),
      .AE_THRESH (1)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .wrt_en       (wrt_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .flush        (flush),
      .clr_err      (clr_err),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Advance one clock; outputs are observed 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] d);
      wrt_en  = 1'b1;
      data_in = d;
      step();
      wrt_en  = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] expect_word);
      rd_en = 1'b1;
      exp_q.push_back(expect_word);
      step();
      rd_en = 1'b0;
   endtask

   // Monitor: every presented word must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rstn && out_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL mon_unexpected actual=%0h required=no_output", data_out);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (data_out !== e) begin
                  n_fail++;
                  $display("FAIL mon_data actual=%0h required=%0h", data_out, e);
               end else begin
                  $display("ok   mon_data = %0h", data_out);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn    = 1'b0;
      wrt_en  = 1'b1;
      data_in = 32'hDEAD_BEEF;
      rd_en   = 1'b0;
      flush   = 1'b0;
      clr_err = 1'b0;

      // 1. Reset held for two cycles while a write is requested.
      step();
      step();
      rstn   = 1'b1;
      wrt_en = 1'b0;
      check("rst_count",     32'(count), 32'd0);
      check("rst_empty",     32'(empty), 32'd1);
      check("rst_aempty",    32'(almost_empty), 32'd1);
      check("rst_full",      32'(full), 32'd0);
      check("rst_afull",     32'(almost_full), 32'd0);
      check("rst_overflow",  32'(overflow), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_data_out",  data_out, 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      step();
      check("post_rst_count", 32'(count), 32'd0);

      // 2. Fill, then overflow.
      do_write(32'd1);
      check("w1_count",  32'(count), 32'd1);
      check("w1_aempty", 32'(almost_empty), 32'd1);
      check("w1_empty",  32'(empty), 32'd0);
      do_write(32'd2);
      check("w2_aempty", 32'(almost_empty), 32'd0);
      check("w2_afull",  32'(almost_full), 32'd0);
      do_write(32'd3);
      check("w3_afull",  32'(almost_full), 32'd1);
      check("w3_full",   32'(full), 32'd0);
      do_write(32'd4);
      check("w4_count",  32'(count), 32'd4);
      check("w4_full",   32'(full), 32'd1);
      check("w4_ovf",    32'(overflow), 32'd0);
      do_write(32'd5);
      check("w5_ovf",    32'(overflow), 32'd1);
      check("w5_count",  32'(count), 32'd4);

      // 3. Drain in order, then one read too many.
      for (int i = 1; i <= 4; i++) begin
         do_read(32'(i));
         check("drain_valid", 32'(out_valid), 32'd1);
      end
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_count", 32'(count), 32'd0);
      check("drain_udf",   32'(underflow), 32'd0);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("rd5_udf",   32'(underflow), 32'd1);
      check("rd5_valid", 32'(out_valid), 32'd0);

      // 4. Full FIFO with simultaneous read and write.
      for (int i = 1; i <= 4; i++) do_write(32'(i));
      check("refill_full", 32'(full), 32'd1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("clr_ovf", 32'(overflow), 32'd0);
      wrt_en  = 1'b1;
      data_in = 32'd9;
      rd_en   = 1'b1;
      exp_q.push_back(32'd1);
      step();
      wrt_en = 1'b0;
      rd_en  = 1'b0;
      check("fullrw_count", 32'(count), 32'd4);
      check("fullrw_valid", 32'(out_valid), 32'd1);
      check("fullrw_ovf",   32'(overflow), 32'd0);
      do_read(32'd2);
      do_read(32'd3);
      do_read(32'd4);
      do_read(32'd9);
      check("fullrw_empty", 32'(empty), 32'd1);

      // 5. Empty FIFO with simultaneous read and write.
      wrt_en  = 1'b1;
      data_in = 32'd10;
      rd_en   = 1'b1;
      step();
      wrt_en = 1'b0;
      rd_en  = 1'b0;
      check("emprw_valid", 32'(out_valid), 32'd0);
      check("emprw_udf",   32'(underflow), 32'd1);
      check("emprw_count", 32'(count), 32'd1);
      check("emprw_ovf",   32'(overflow), 32'd0);
      do_read(32'd10);
      check("emprw_rd_valid", 32'(out_valid), 32'd1);
      check("emprw_rd_count", 32'(count), 32'd0);
      step();
      check("hold_valid", 32'(out_valid), 32'd0);
      check("hold_data",  data_out, 32'd10);

      // 6. Mid-fill flush with a concurrent write, then clear errors.
      do_write(32'd11);
      do_write(32'd12);
      do_write(32'd13);
      check("pre_flush_count", 32'(count), 32'd3);
      flush   = 1'b1;
      wrt_en  = 1'b1;
      data_in = 32'd14;
      step();
      flush  = 1'b0;
      wrt_en = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_empty", 32'(empty), 32'd1);
      check("flush_ovf",   32'(overflow), 32'd0);
      check("flush_udf",   32'(underflow), 32'd1);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_data",  data_out, 32'd10);

      // Clear and a new underflow in the same cycle: the new error wins.
      clr_err = 1'b1;
      rd_en   = 1'b1;
      step();
      rd_en = 1'b0;
      check("clr_set_udf", 32'(underflow), 32'd1);
      step();
      clr_err = 1'b0;
      check("clr_ovf2", 32'(overflow), 32'd0);
      check("clr_udf2", 32'(underflow), 32'd0);

      // Dropped flush-cycle write must not resurface; fresh data must.
      do_write(32'd15);
      check("post_flush_count", 32'(count), 32'd1);
      do_read(32'd15);

      step();
      step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
